inst_fetch: RTL and testbench

Instruction fetch stage: the initiator side of the instruction-memory interface. Owns the PC, drives chip-enable and byte address to the combinational instruction ROM, and captures each returned word with its PC into a 2-entry fetch buffer. Presents {pc, inst} to decode over a valid/ready handshake. Accepts branch redirects from decode, which flush the buffer.

---
 rtl/inst_fetch_pkg.sv | 23 ++
 rtl/inst_fetch_fetch_buf.sv | 55 +++++
 rtl/inst_fetch.sv | 64 ++++++
 tb/tb_inst_fetch.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared bus defines and fetch-stage types used by inst_fetch and its fetch buffer.
`ifndef INST_FETCH_DEFINES
`define INST_FETCH_DEFINES
`define InstAddrBus   31:0
`define InstBus       31:0
`define ZeroWord      32'h0000_0000
`define RstEnable     1'b1
`define ChipEnable    1'b1
`define ChipDisable   1'b0
`define FetchBufDepth 2
`endif

package inst_fetch_pkg;

  // One buffered fetch: the PC it was read from and the returned word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam int CNT_W = 2;

endpackage

// File: rtl/inst_fetch_fetch_buf.sv
// Two-entry synchronous FIFO of {pc, inst}; flush beats push and pop.
module fetch_buf
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = `FetchBufDepth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     push_data,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t     mem [DEPTH];
  logic             hd_q;
  logic             tl_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop & (cnt_q != '0) & ~flush;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push & ~flush & ((cnt_q != CNT_W'(DEPTH)) | do_pop);

  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      hd_q  <= 1'b0;
      tl_q  <= 1'b0;
      cnt_q <= '0;
    end else if (flush) begin
      hd_q  <= 1'b0;
      tl_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (do_pop)  hd_q <= ~hd_q;
      if (do_push) tl_q <= ~tl_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst != `RstEnable && do_push) mem[tl_q] <= push_data;
  end

  assign count = cnt_q;
  assign head  = mem[hd_q];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns PC and ROM chip enable, buffers fetched words for decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = `FetchBufDepth
) (
  input  logic                clk,
  input  logic                rst,
  output logic                rom_ce_o,
  output logic [`InstAddrBus] rom_addr_o,
  input  logic [`InstBus]     rom_inst_i,
  input  logic                branch_flag_i,
  input  logic [`InstAddrBus] branch_target_i,
  output logic                id_valid_o,
  output logic [`InstAddrBus] id_pc_o,
  output logic [`InstBus]     id_inst_o,
  input  logic                id_ready_i
);

  logic             ce_q;
  logic [31:0]      pc_q;
  logic             pop;
  logic             fetch;
  logic             flush;
  logic [CNT_W-1:0] count;
  fetch_entry_t     push_data;
  fetch_entry_t     head;

  assign flush     = ce_q & branch_flag_i;
  assign pop       = id_valid_o & id_ready_i;
  assign fetch     = ce_q & ~branch_flag_i & ((count < CNT_W'(BUF_DEPTH)) | pop);
  assign push_data = '{pc: pc_q, inst: rom_inst_i};

  always_ff @(posedge clk) begin
    if (rst == `RstEnable) ce_q <= `ChipDisable;
    else                   ce_q <= `ChipEnable;
  end

  // A redirect overrides any fetch; a stalled fetch simply re-reads the same address.
  always_ff @(posedge clk) begin
    if (rst == `RstEnable)  pc_q <= RESET_PC;
    else if (flush)         pc_q <= {branch_target_i[31:2], 2'b00};
    else if (fetch)         pc_q <= pc_q + 32'd4;
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (fetch),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_data),
    .count     (count),
    .head      (head)
  );

  assign rom_ce_o   = ce_q;
  assign rom_addr_o = pc_q;
  assign id_valid_o = (count != '0);
  assign id_pc_o    = id_valid_o ? head.pc   : `ZeroWord;
  assign id_inst_o  = id_valid_o ? head.inst : `ZeroWord;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch against a queue-based fetch model; two instances cover normal and wrapping reset PCs.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br  = 1'b0;
  logic [31:0] tgt = '0;
  logic        rdy = 1'b0;

  logic        ce   [2];
  logic [31:0] addr [2];
  logic [31:0] inst [2];
  logic        vld  [2];
  logic [31:0] ipc  [2];
  logic [31:0] iin  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign inst[0] = rom(addr[0]);
  assign inst[1] = rom(addr[1]);

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .rom_ce_o(ce[0]), .rom_addr_o(addr[0]), .rom_inst_i(inst[0]),
    .branch_flag_i(br), .branch_target_i(tgt), .id_valid_o(vld[0]), .id_pc_o(ipc[0]),
    .id_inst_o(iin[0]), .id_ready_i(rdy)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst(rst), .rom_ce_o(ce[1]), .rom_addr_o(addr[1]), .rom_inst_i(inst[1]),
    .branch_flag_i(br), .branch_target_i(tgt), .id_valid_o(vld[1]), .id_pc_o(ipc[1]),
    .id_inst_o(iin[1]), .id_ready_i(rdy)
  );

  // Reference model: the buffer is a queue of {pc, inst} holding at most two fetches.
  logic [31:0] rpc  [2] = '{32'h0000_0000, 32'hFFFF_FFF8};
  bit          m_ce [2];
  logic [31:0] m_pc [2];
  logic [63:0] mq   [2][$];
  bit          m_ok = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      logic        ev;
      logic [63:0] eh;
      ev = (mq[k].size() != 0);
      eh = ev ? mq[k][0] : 64'h0;
      chk($sformatf("rom_ce%0d", k),   ce[k],   m_ce[k]);
      chk($sformatf("rom_addr%0d", k), addr[k], m_pc[k]);
      chk($sformatf("id_valid%0d", k), vld[k],  ev);
      chk($sformatf("id_pc%0d", k),    ipc[k],  eh[63:32]);
      chk($sformatf("id_inst%0d", k),  iin[k],  eh[31:0]);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_ce[k] = 1'b0;
        m_pc[k] = rpc[k];
        mq[k].delete();
      end else begin
        if (m_ce[k] && br) begin
          mq[k].delete();
          m_pc[k] = {tgt[31:2], 2'b00};
        end else begin
          if (mq[k].size() != 0 && rdy) void'(mq[k].pop_front());
          if (m_ce[k] && mq[k].size() < 2) begin
            mq[k].push_back({m_pc[k], rom(m_pc[k])});
            m_pc[k] = m_pc[k] + 32'd4;
          end
        end
        m_ce[k] = 1'b1;
      end
    end
    if (rst) m_ok = 1'b1;
  endtask

  // One cycle: drive inputs after the falling edge, compare, then advance the model.
  task automatic step(input bit r, input bit b, input logic [31:0] t, input bit rd);
    @(negedge clk);
    rst = r; br = b; tgt = t; rdy = rd;
    #1;
    if (m_ok) model_check();
    model_update();
  endtask

  task automatic run(input int n, input bit rd);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, rd);
  endtask

  initial begin
    // Startup with decode always ready: back-to-back delivery from the reset PC.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    run(8, 1'b1);

    // Decode stalls from R+2: buffer fills, PC holds, then drains in order.
    step(1'b1, 1'b0, 32'h0, 1'b1);
    run(1, 1'b1);
    run(5, 1'b0);
    run(4, 1'b1);

    // Redirect while full to a misaligned target.
    run(4, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0043, 1'b0);
    run(5, 1'b1);

    // Redirect together with a pop at count 1.
    run(3, 1'b1);
    step(1'b0, 1'b1, 32'h0000_1234, 1'b1);
    run(4, 1'b1);

    // One-cycle reset pulse with a full buffer, then startup repeats.
    run(4, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0100, 1'b1);
    run(6, 1'b1);

    // Random traffic, including redirects near the top of the address space.
    for (int i = 0; i < 3000; i++) begin
      bit          r, b, rd;
      logic [31:0] t;
      r  = ($urandom_range(0, 199) == 0);
      b  = ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 9) < 7);
      t  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(r, b, t, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
